// File: rtl/csr_pkg.sv
// csr_pkg
//   Shared definitions for the machine-mode CSR file: CSR addresses, the
//   CSR operation encoding, mstatus bit positions, the first external
//   interrupt bit position, and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_BASE         = 16;

  // CSR data is 32 bits wide in this generation of the core.
  function automatic logic [31:0] csr_wval(input csr_op_e op,
                                           input logic [31:0] old_val,
                                           input logic [31:0] wd);
    case (op)
      CSR_OP_RW: csr_wval = wd;
      CSR_OP_RS: csr_wval = old_val | wd;
      CSR_OP_RC: csr_wval = old_val & ~wd;
      default:   csr_wval = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64
//   64-bit free-running counter with independent 32-bit half loads. A load of
//   either half suppresses the increment for that cycle; wraps to 0.
// Ports:
//   clk_i    core clock
//   rst_ni   asynchronous active-low reset
//   inc_i    count enable for this cycle
//   wr_lo_i  load bits [31:0] from wd_i
//   wr_hi_i  load bits [63:32] from wd_i
//   wd_i     load data
//   cnt_o    current count
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wd_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_q[31:0]  <= wd_i;
      if (wr_hi_i) cnt_q[63:32] <= wd_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_irq_file.sv
// csr_irq_file
//   Machine-mode CSR file with interrupt controller and 64-bit performance
//   counters. CSR reads are combinational (old value), writes are clocked.
//   Handles exception/interrupt entry and mret, and presents a prioritised
//   interrupt request together with its trap target PC.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   csr_req_i, op_i, addr_i,   CSR instruction: valid, operation, address,
//   wd_i                       write operand
//   rd_o, illegal_o            read data, unmapped-address flag
//   trap_i, mcause_i, pc_i     exception entry, its cause, faulting PC
//   mret_i                     mret retiring
//   irq_i, irq_ack_i           interrupt lines, core takes the interrupt
//   instret_i                  instruction retired
//   irq_req_o, trap_pc_o       interrupt request, trap entry target
//   mepc_o                     mret target
module csr_irq_file
  import csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          IRQ_NUM   = 16,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               csr_req_i,
  input  logic [1:0]         op_i,
  input  logic [11:0]        addr_i,
  input  logic [XLEN-1:0]    wd_i,
  output logic [XLEN-1:0]    rd_o,
  output logic               illegal_o,
  input  logic               trap_i,
  input  logic [XLEN-1:0]    mcause_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               mret_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic               irq_ack_i,
  input  logic               instret_i,
  output logic               irq_req_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic [XLEN-1:0]    mepc_o
);

  logic               mst_mie_q;
  logic               mst_mpie_q;
  logic [XLEN-1:0]    mie_q;
  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mscratch_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [IRQ_NUM-1:0] irq_q;
  logic [63:0]        mcycle;
  logic [63:0]        minstret;

  logic [XLEN-1:0]    mstatus_val;
  logic [XLEN-1:0]    mip_val;
  logic [XLEN-1:0]    rdata;
  logic               addr_mapped;
  csr_op_e            op;
  logic               csr_we;
  logic [XLEN-1:0]    wval;

  logic [IRQ_NUM-1:0] irq_pend;
  logic [4:0]         irq_sel;
  logic [XLEN-1:0]    irq_code;
  logic [XLEN-1:0]    irq_cause;
  logic               irq_take;
  logic               trap_entry;
  logic [XLEN-1:0]    tvec_base;

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE_BIT]  = mst_mie_q;
    mstatus_val[MSTATUS_MPIE_BIT] = mst_mpie_q;
  end

  assign mip_val = XLEN'(irq_q) << IRQ_BASE;

  always_comb begin
    rdata       = '0;
    addr_mapped = 1'b1;
    case (addr_i)
      CSR_MSTATUS:   rdata = mstatus_val;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MIP:       rdata = mip_val;
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
      default:       addr_mapped = 1'b0;
    endcase
  end

  assign rd_o      = rdata;
  assign illegal_o = csr_req_i & ~addr_mapped;

  assign op     = csr_op_e'(op_i);
  assign csr_we = csr_req_i & addr_mapped & (op != CSR_OP_NONE);
  assign wval   = csr_wval(op, rdata, wd_i);

  // Lowest-numbered pending-and-enabled line wins.
  assign irq_pend = irq_q & mie_q[IRQ_BASE +: IRQ_NUM];

  always_comb begin
    irq_sel = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_sel = 5'(i);
    end
  end

  assign irq_code  = XLEN'(IRQ_BASE) + XLEN'(irq_sel);
  assign irq_cause = {1'b1, irq_code[XLEN-2:0]};
  assign irq_req_o = mst_mie_q & (|irq_pend);
  assign irq_take  = irq_ack_i & irq_req_o;
  assign trap_entry = trap_i | irq_take;

  // A synchronous exception outranks a pending interrupt, so it always
  // goes to the base address even in vectored mode.
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_pc_o = (mtvec_q[1:0] == 2'b01 && irq_req_o && !trap_i)
                   ? tvec_base + (irq_code << 2)
                   : tvec_base;

  assign mepc_o = mepc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= XLEN'(MTVEC_RST);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      irq_q      <= '0;
    end else begin
      irq_q <= irq_i;

      // These registers are not touched by trap/mret, so their CSR writes
      // always land.
      if (csr_we && addr_i == CSR_MIE)      mie_q      <= wval;
      if (csr_we && addr_i == CSR_MTVEC)    mtvec_q    <= wval;
      if (csr_we && addr_i == CSR_MSCRATCH) mscratch_q <= wval;

      if (trap_entry) begin
        mepc_q     <= {pc_i[XLEN-1:2], 2'b00};
        mcause_q   <= trap_i ? mcause_i : irq_cause;
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else begin
        if (csr_we && addr_i == CSR_MSTATUS) begin
          mst_mie_q  <= wval[MSTATUS_MIE_BIT];
          mst_mpie_q <= wval[MSTATUS_MPIE_BIT];
        end
        if (csr_we && addr_i == CSR_MEPC)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
        if (csr_we && addr_i == CSR_MCAUSE) mcause_q <= wval;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && addr_i == CSR_MCYCLE),
    .wr_hi_i (csr_we && addr_i == CSR_MCYCLEH),
    .wd_i    (wval),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (instret_i),
    .wr_lo_i (csr_we && addr_i == CSR_MINSTRET),
    .wr_hi_i (csr_we && addr_i == CSR_MINSTRETH),
    .wd_i    (wval),
    .cnt_o   (minstret)
  );

endmodule

// File: tb/tb_csr_irq_file.sv
module tb_csr_irq_file;
  import csr_pkg::*;

  localparam int          XLEN      = 32;
  localparam int          IRQ_NUM   = 16;
  localparam logic [31:0] MTVEC_RST = 32'h0000_8000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        csr_req_i;
  logic [1:0]  op_i;
  logic [11:0] addr_i;
  logic [31:0] wd_i;
  logic [31:0] rd_o;
  logic        illegal_o;
  logic        trap_i;
  logic [31:0] mcause_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic [15:0] irq_i;
  logic        irq_ack_i;
  logic        instret_i;
  logic        irq_req_o;
  logic [31:0] trap_pc_o;
  logic [31:0] mepc_o;

  int checks   = 0;
  int failures = 0;

  csr_irq_file #(.XLEN(XLEN), .IRQ_NUM(IRQ_NUM), .MTVEC_RST(MTVEC_RST)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .csr_req_i (csr_req_i),
    .op_i      (op_i),
    .addr_i    (addr_i),
    .wd_i      (wd_i),
    .rd_o      (rd_o),
    .illegal_o (illegal_o),
    .trap_i    (trap_i),
    .mcause_i  (mcause_i),
    .pc_i      (pc_i),
    .mret_i    (mret_i),
    .irq_i     (irq_i),
    .irq_ack_i (irq_ack_i),
    .instret_i (instret_i),
    .irq_req_o (irq_req_o),
    .trap_pc_o (trap_pc_o),
    .mepc_o    (mepc_o)
  );

  always #10 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    csr_req_i = 1'b0; op_i = 2'd0; addr_i = 12'h0; wd_i = '0;
    trap_i = 1'b0; mcause_i = '0; pc_i = '0; mret_i = 1'b0;
    irq_ack_i = 1'b0; instret_i = 1'b0;
  endtask

  task automatic csr_op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic ill);
    @(negedge clk_i);
    csr_req_i = 1'b1; op_i = o; addr_i = a; wd_i = d;
    #1; r = rd_o; ill = illegal_o;
    @(posedge clk_i); #1;
    idle();
  endtask

  task automatic csr_wr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic ill;
    csr_op(o, a, d, r, ill);
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] r);
    @(negedge clk_i);
    csr_req_i = 1'b1; op_i = 2'd0; addr_i = a;
    #1; r = rd_o;
    csr_req_i = 1'b0; addr_i = 12'h0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [11:0] addrs [11];
    logic [31:0] exps  [11];
    logic [31:0] r;
    addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
              CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
    exps  = '{32'h0, 32'h0, MTVEC_RST, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    idle(); irq_i = '0; rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      csr_req_i = 1'b1; addr_i = addrs[i];
      #1;
      checks++;
      if (rd_o !== exps[i]) begin
        failures++; $display("FAIL reset_value addr=%h got=%h exp=%h", addrs[i], rd_o, exps[i]);
      end
      checks++;
      if (illegal_o !== 1'b0) begin
        failures++; $display("FAIL reset_illegal addr=%h got=%b exp=0", addrs[i], illegal_o);
      end
    end
    idle();
    checks++;
    if (irq_req_o !== 1'b0) begin
      failures++; $display("FAIL reset_irq_req got=%b exp=0", irq_req_o);
    end
    checks++;
    if (trap_pc_o !== MTVEC_RST) begin
      failures++; $display("FAIL reset_trap_pc got=%h exp=%h", trap_pc_o, MTVEC_RST);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    csr_rd(CSR_MCYCLE, r);
    checks++;
    if (r !== 32'd1) begin
      failures++; $display("FAIL reset_release_mcycle got=%h exp=1", r);
    end
    csr_rd(CSR_MTVEC, r);
    checks++;
    if (r !== MTVEC_RST) begin
      failures++; $display("FAIL reset_release_mtvec got=%h exp=%h", r, MTVEC_RST);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_rw_rs_rc();
    logic [31:0] r;
    logic ill;
    csr_wr(CSR_OP_RW, CSR_MSCRATCH, 32'hF0F0_F0F0);
    csr_rd(CSR_MSCRATCH, r);
    checks++;
    if (r !== 32'hF0F0_F0F0) begin
      failures++; $display("FAIL rw_mscratch got=%h exp=F0F0F0F0", r);
    end
    csr_wr(CSR_OP_RS, CSR_MSCRATCH, 32'h0000_000F);
    csr_rd(CSR_MSCRATCH, r);
    checks++;
    if (r !== 32'hF0F0_F0FF) begin
      failures++; $display("FAIL rs_mscratch got=%h exp=F0F0F0FF", r);
    end
    csr_wr(CSR_OP_RC, CSR_MSCRATCH, 32'h0000_00F0);
    csr_rd(CSR_MSCRATCH, r);
    checks++;
    if (r !== 32'hF0F0_F00F) begin
      failures++; $display("FAIL rc_mscratch got=%h exp=F0F0F00F", r);
    end

    @(negedge clk_i);
    csr_req_i = 1'b0; addr_i = 12'h7C0;
    #1;
    checks++;
    if (illegal_o !== 1'b0) begin
      failures++; $display("FAIL illegal_without_req got=%b exp=0", illegal_o);
    end
    idle();

    csr_op(CSR_OP_RW, 12'h7C0, 32'h1234_5678, r, ill);
    checks++;
    if (ill !== 1'b1 || r !== 32'h0) begin
      failures++; $display("FAIL illegal_7c0 ill=%b rd=%h exp ill=1 rd=0", ill, r);
    end
    csr_op(CSR_OP_RW, 12'h301, 32'hFFFF_FFFF, r, ill);
    checks++;
    if (ill !== 1'b1 || r !== 32'h0) begin
      failures++; $display("FAIL illegal_301 ill=%b rd=%h exp ill=1 rd=0", ill, r);
    end
    csr_rd(CSR_MSCRATCH, r);
    checks++;
    if (r !== 32'hF0F0_F00F) begin
      failures++; $display("FAIL illegal_no_change_mscratch got=%h exp=F0F0F00F", r);
    end
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0) begin
      failures++; $display("FAIL illegal_no_change_mstatus got=%h exp=0", r);
    end

    csr_op(CSR_OP_RW, CSR_MIP, 32'hFFFF_FFFF, r, ill);
    checks++;
    if (ill !== 1'b0) begin
      failures++; $display("FAIL mip_write_illegal got=%b exp=0", ill);
    end
    csr_rd(CSR_MIP, r);
    checks++;
    if (r !== 32'h0) begin
      failures++; $display("FAIL mip_readonly got=%h exp=0", r);
    end

    csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0088) begin
      failures++; $display("FAIL mstatus_mask got=%h exp=00000088", r);
    end
    csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'h0);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_vectored_irq();
    logic [31:0] r;
    csr_wr(CSR_OP_RW, CSR_MTVEC, 32'h0000_0101);
    csr_wr(CSR_OP_RW, CSR_MIE, 32'h0003_0000);
    csr_wr(CSR_OP_RS, CSR_MSTATUS, 32'h0000_0008);
    @(negedge clk_i);
    irq_i = 16'h0003;
    #1;
    checks++;
    if (irq_req_o !== 1'b0) begin
      failures++; $display("FAIL irq_latency_early got=%b exp=0", irq_req_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (irq_req_o !== 1'b1) begin
      failures++; $display("FAIL irq_req got=%b exp=1", irq_req_o);
    end
    checks++;
    if (trap_pc_o !== 32'h0000_0140) begin
      failures++; $display("FAIL vectored_trap_pc got=%h exp=00000140", trap_pc_o);
    end
    irq_ack_i = 1'b1; pc_i = 32'h1234_5678;
    @(posedge clk_i); #1; idle();
    @(negedge clk_i); #1;
    checks++;
    if (irq_req_o !== 1'b0) begin
      failures++; $display("FAIL irq_req_after_entry got=%b exp=0", irq_req_o);
    end
    csr_rd(CSR_MCAUSE, r);
    checks++;
    if (r !== 32'h8000_0010) begin
      failures++; $display("FAIL irq_mcause got=%h exp=80000010", r);
    end
    csr_rd(CSR_MEPC, r);
    checks++;
    if (r !== 32'h1234_5678 || mepc_o !== 32'h1234_5678) begin
      failures++; $display("FAIL irq_mepc got=%h mepc_o=%h exp=12345678", r, mepc_o);
    end
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0080) begin
      failures++; $display("FAIL irq_mstatus got=%h exp=00000080", r);
    end

    @(negedge clk_i);
    irq_ack_i = 1'b1; pc_i = 32'hDEAD_0000;
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MEPC, r);
    checks++;
    if (r !== 32'h1234_5678) begin
      failures++; $display("FAIL ack_ignored_mepc got=%h exp=12345678", r);
    end

    irq_i = 16'h0002;
    csr_wr(CSR_OP_RS, CSR_MSTATUS, 32'h0000_0008);
    @(negedge clk_i); #1;
    checks++;
    if (irq_req_o !== 1'b1 || trap_pc_o !== 32'h0000_0144) begin
      failures++; $display("FAIL irq1_req req=%b pc=%h exp req=1 pc=00000144", irq_req_o, trap_pc_o);
    end
    irq_ack_i = 1'b1; pc_i = 32'h0000_2000;
    @(posedge clk_i); #1; idle(); irq_i = '0;
    csr_rd(CSR_MCAUSE, r);
    checks++;
    if (r !== 32'h8000_0011) begin
      failures++; $display("FAIL irq1_mcause got=%h exp=80000011", r);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_trap_mret();
    logic [31:0] r;
    csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'h0000_0008);
    @(negedge clk_i);
    trap_i = 1'b1; mcause_i = 32'd2; pc_i = 32'hABCD_0000;
    csr_req_i = 1'b1; op_i = CSR_OP_RW; addr_i = CSR_MEPC; wd_i = 32'h5555_5554;
    #1;
    checks++;
    if (trap_pc_o !== 32'h0000_0100) begin
      failures++; $display("FAIL exc_trap_pc got=%h exp=00000100", trap_pc_o);
    end
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MEPC, r);
    checks++;
    if (r !== 32'hABCD_0000) begin
      failures++; $display("FAIL exc_mepc_priority got=%h exp=ABCD0000", r);
    end
    csr_rd(CSR_MCAUSE, r);
    checks++;
    if (r !== 32'd2) begin
      failures++; $display("FAIL exc_mcause got=%h exp=2", r);
    end
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0080) begin
      failures++; $display("FAIL exc_mstatus got=%h exp=00000080", r);
    end

    @(negedge clk_i);
    mret_i = 1'b1;
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0088 || mepc_o !== 32'hABCD_0000) begin
      failures++; $display("FAIL mret_mstatus got=%h mepc_o=%h exp 00000088 ABCD0000", r, mepc_o);
    end

    @(negedge clk_i);
    mret_i = 1'b1;
    csr_req_i = 1'b1; op_i = CSR_OP_RW; addr_i = CSR_MSTATUS; wd_i = 32'h0;
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0088) begin
      failures++; $display("FAIL mret_beats_write got=%h exp=00000088", r);
    end

    @(negedge clk_i);
    trap_i = 1'b1; mcause_i = 32'd5; pc_i = 32'h0000_3000;
    csr_req_i = 1'b1; op_i = CSR_OP_RW; addr_i = CSR_MSCRATCH; wd_i = 32'h1111_2222;
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MSCRATCH, r);
    checks++;
    if (r !== 32'h1111_2222) begin
      failures++; $display("FAIL trap_keeps_mscratch_write got=%h exp=11112222", r);
    end
    csr_rd(CSR_MSTATUS, r);
    checks++;
    if (r !== 32'h0000_0080) begin
      failures++; $display("FAIL trap2_mstatus got=%h exp=00000080", r);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_counters();
    logic [31:0] lo, hi, r;
    logic [63:0] exp64;
    int n;
    csr_wr(CSR_OP_RW, CSR_MCYCLEH, 32'hFFFF_FFFF);
    csr_wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFE);
    exp64 = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      csr_req_i = 1'b1; addr_i = CSR_MCYCLE;
      #1; lo = rd_o;
      addr_i = CSR_MCYCLEH;
      #1; hi = rd_o;
      idle();
      checks++;
      if ({hi, lo} !== exp64) begin
        failures++; $display("FAIL mcycle_wrap step=%0d got=%h exp=%h", k, {hi, lo}, exp64);
      end
      exp64 = exp64 + 64'd1;
    end

    csr_wr(CSR_OP_RW, CSR_MINSTRETH, 32'h0);
    csr_wr(CSR_OP_RW, CSR_MINSTRET, 32'h0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      instret_i = 1'($urandom_range(0, 1));
      if (instret_i) n++;
    end
    @(negedge clk_i); instret_i = 1'b0;
    csr_rd(CSR_MINSTRET, r);
    checks++;
    if (r !== 32'(n)) begin
      failures++; $display("FAIL minstret_count got=%0d exp=%0d", r, n);
    end
    @(negedge clk_i);
    csr_req_i = 1'b1; op_i = CSR_OP_RW; addr_i = CSR_MINSTRET; wd_i = 32'd100; instret_i = 1'b1;
    @(posedge clk_i); #1; idle();
    csr_rd(CSR_MINSTRET, r);
    checks++;
    if (r !== 32'd100) begin
      failures++; $display("FAIL minstret_write_suppress got=%0d exp=100", r);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid();
    csr_wr(CSR_OP_RW, CSR_MIE, 32'h0001_0000);
    irq_i = 16'h0001;
    csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'h0000_0008);
    @(negedge clk_i); #1;
    checks++;
    if (irq_req_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset_irq_req got=%b exp=1", irq_req_o);
    end
    csr_req_i = 1'b1; addr_i = CSR_MCYCLE;
    #1;
    checks++;
    if (rd_o === 32'h0) begin
      failures++; $display("FAIL pre_reset_mcycle_running got=%h exp=nonzero", rd_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (irq_req_o !== 1'b0) begin
      failures++; $display("FAIL async_reset_irq_req got=%b exp=0", irq_req_o);
    end
    addr_i = CSR_MCYCLE; #1;
    checks++;
    if (rd_o !== 32'h0) begin
      failures++; $display("FAIL async_reset_mcycle got=%h exp=0", rd_o);
    end
    addr_i = CSR_MSTATUS; #1;
    checks++;
    if (rd_o !== 32'h0) begin
      failures++; $display("FAIL async_reset_mstatus got=%h exp=0", rd_o);
    end
    addr_i = CSR_MIE; #1;
    checks++;
    if (rd_o !== 32'h0) begin
      failures++; $display("FAIL async_reset_mie got=%h exp=0", rd_o);
    end
    addr_i = CSR_MTVEC; #1;
    checks++;
    if (rd_o !== MTVEC_RST) begin
      failures++; $display("FAIL async_reset_mtvec got=%h exp=%h", rd_o, MTVEC_RST);
    end
    addr_i = CSR_MIP; #1;
    checks++;
    if (rd_o !== 32'h0) begin
      failures++; $display("FAIL async_reset_mip got=%h exp=0", rd_o);
    end
    idle(); irq_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: architectural register values kept as plain variables.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit ok);
    ok = 1'b1;
    case (a)
      CSR_MSTATUS:   return m_mstatus;
      CSR_MIE:       return m_mie;
      CSR_MTVEC:     return m_mtvec;
      CSR_MSCRATCH:  return m_mscratch;
      CSR_MEPC:      return m_mepc;
      CSR_MCAUSE:    return m_mcause;
      CSR_MIP:       return m_mip;
      CSR_MCYCLE:    return m_cyc[31:0];
      CSR_MCYCLEH:   return m_cyc[63:32];
      CSR_MINSTRET:  return m_ins[31:0];
      CSR_MINSTRETH: return m_ins[63:32];
      default: begin ok = 1'b0; return 32'h0; end
    endcase
  endfunction

  task automatic test_random();
    logic [11:0] pool [14];
    logic [31:0] old_v, wv, en, exp_tpc, cause;
    bit          ok, exp_req, we, take, found;
    int          sel;
    pool = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MIP,
             CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, 12'h7C0, 12'h301, 12'hB01};
    idle(); irq_i = '0; rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mip = 0; m_cyc = 0; m_ins = 0;

    for (int cyc = 0; cyc < 1200; cyc++) begin
      csr_req_i = ($urandom_range(0, 1) == 1);
      op_i      = 2'($urandom_range(0, 3));
      addr_i    = pool[$urandom_range(0, 13)];
      wd_i      = $urandom;
      trap_i    = ($urandom_range(0, 15) == 0);
      mcause_i  = $urandom;
      pc_i      = $urandom;
      mret_i    = ($urandom_range(0, 7) == 0);
      irq_ack_i = ($urandom_range(0, 2) == 0);
      instret_i = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) irq_i = 16'($urandom) & 16'($urandom);
      #1;

      old_v   = m_read(addr_i, ok);
      en      = m_mie & m_mip;
      exp_req = m_mstatus[3] && (en != 0);
      sel = 0; found = 0;
      for (int i = 0; i < IRQ_NUM; i++) begin
        if (!found && en[16 + i]) begin sel = i; found = 1; end
      end
      exp_tpc = m_mtvec & 32'hFFFF_FFFC;
      if (m_mtvec[1:0] == 2'b01 && exp_req && !trap_i) exp_tpc = exp_tpc + 32'(4 * (16 + sel));

      checks++;
      if (rd_o !== old_v) begin
        failures++; $display("FAIL rand_rd cyc=%0d addr=%h got=%h exp=%h", cyc, addr_i, rd_o, old_v);
      end
      checks++;
      if (illegal_o !== (csr_req_i && !ok)) begin
        failures++; $display("FAIL rand_illegal cyc=%0d addr=%h got=%b exp=%b", cyc, addr_i, illegal_o, csr_req_i && !ok);
      end
      checks++;
      if (irq_req_o !== exp_req) begin
        failures++; $display("FAIL rand_irq_req cyc=%0d got=%b exp=%b", cyc, irq_req_o, exp_req);
      end
      checks++;
      if (trap_pc_o !== exp_tpc) begin
        failures++; $display("FAIL rand_trap_pc cyc=%0d got=%h exp=%h", cyc, trap_pc_o, exp_tpc);
      end
      checks++;
      if (mepc_o !== m_mepc) begin
        failures++; $display("FAIL rand_mepc_o cyc=%0d got=%h exp=%h", cyc, mepc_o, m_mepc);
      end

      @(posedge clk_i);
      we   = csr_req_i && ok && (op_i != 2'd0);
      wv   = (op_i == 2'd1) ? wd_i : (op_i == 2'd2) ? (old_v | wd_i) : (old_v & ~wd_i);
      take = irq_ack_i && exp_req;
      cause = 32'h8000_0000 | 32'(16 + sel);

      if (we && addr_i == CSR_MCYCLE)        m_cyc[31:0]  = wv;
      else if (we && addr_i == CSR_MCYCLEH)  m_cyc[63:32] = wv;
      else                                   m_cyc = m_cyc + 1;
      if (we && addr_i == CSR_MINSTRET)       m_ins[31:0]  = wv;
      else if (we && addr_i == CSR_MINSTRETH) m_ins[63:32] = wv;
      else if (instret_i)                     m_ins = m_ins + 1;

      if (we && addr_i == CSR_MIE)      m_mie = wv;
      if (we && addr_i == CSR_MTVEC)    m_mtvec = wv;
      if (we && addr_i == CSR_MSCRATCH) m_mscratch = wv;

      if (trap_i || take) begin
        m_mepc    = pc_i & 32'hFFFF_FFFC;
        m_mcause  = trap_i ? mcause_i : cause;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (mret_i) begin
        m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
      end else if (we) begin
        if (addr_i == CSR_MSTATUS) m_mstatus = wv & 32'h88;
        if (addr_i == CSR_MEPC)    m_mepc = wv & 32'hFFFF_FFFC;
        if (addr_i == CSR_MCAUSE)  m_mcause = wv;
      end
      m_mip = {irq_i, 16'h0};

      @(negedge clk_i);
    end
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    irq_i  = '0;
    idle();
    test_reset();
    test_rw_rs_rc();
    test_vectored_irq();
    test_trap_mret();
    test_counters();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_irq_file.md
# csr_irq_file

Parametrised machine-mode CSR file with an integrated interrupt controller and 64-bit performance counters. It sits beside the decoder and the PC logic in the core. It serves CSR instructions with combinational read and clocked write. It also performs trap entry and mret state updates, and presents a prioritised interrupt request with its trap target PC.

## Interface
- `XLEN`, 32: CSR data width; fixed at 32 for this generation.
- `IRQ_NUM`, 16, range 1..16: external interrupt lines, mapped to `mie`/`mip` bits [16+IRQ_NUM-1:16].
- `MTVEC_RST`, 32'h0: reset value of `mtvec`.

- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low
- `csr_req_i`  in  1  CSR instruction valid this cycle
- `op_i`  in  2  1=RW, 2=RS (set), 3=RC (clear), 0=no write
- `addr_i`  in  12  CSR address
- `wd_i`  in  XLEN  write operand
- `rd_o`  out  XLEN  read data; old value, combinational
- `illegal_o`  out  1  `csr_req_i` to an unmapped address
- `trap_i`  in  1  synchronous exception entry
- `mcause_i`  in  XLEN  exception cause, used with `trap_i`
- `pc_i`  in  XLEN  PC of the faulting or interrupted instruction
- `mret_i`  in  1  mret retiring
- `irq_i`  in  IRQ_NUM  level interrupt lines, synchronous to `clk_i`
- `irq_ack_i`  in  1  core takes the pending interrupt this cycle
- `instret_i`  in  1  one instruction retired
- `irq_req_o`  out  1  interrupt pending, enabled and globally enabled
- `trap_pc_o`  out  XLEN  next-PC target for trap entry
- `mepc_o`  out  XLEN  mret target

## Operation
- **Mapped registers and reset values:**
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are writable; reset 0.
  - `mie` 0x304: reset 0.
  - `mtvec` 0x305: reset `MTVEC_RST`.
  - `mscratch` 0x340: reset 0.
  - `mepc` 0x341: bits [1:0] read 0; reset 0.
  - `mcause` 0x342: reset 0.
  - `mip` 0x344: read-only; writes ignored, not illegal.
  - `mcycle` 0xB00 / `mcycleh` 0xB80: reset 0.
  - `minstret` 0xB02 / `minstreth` 0xB82: reset 0.
- **Write value:**
  - RW: `wd_i`.
  - RS: `old | wd_i`.
  - RC: `old & ~wd_i`.
  - Unwritable bits keep their value.
- **Illegal access:** unmapped address with `csr_req_i`=1 gives `illegal_o`=1, `rd_o`=0 and no state change. `illegal_o` is 0 when `csr_req_i`=0.
- **Interrupt pending:** `mip[16+i]` is a register sampling `irq_i[i]` each cycle, a one-cycle pipeline; it is level, not latched.
- **Interrupt request:** `irq_req_o` = `mstatus.MIE & |(mip & mie)`. The selected cause is the lowest-numbered pending-and-enabled line.
- **Interrupt cause:** {1'b1, 31'(16+i)}.
- **Exception entry** (`trap_i`):
  - `mepc`<=`pc_i`, `mcause`<=`mcause_i`.
  - MPIE<=MIE, MIE<=0.
- **Interrupt entry** (`irq_ack_i` while `irq_req_o`=1): same as exception entry, with `mcause`<=selected interrupt cause. `irq_ack_i` while `irq_req_o`=0 is ignored.
- **mret:** MIE<=MPIE, MPIE<=1.
- **trap_pc_o:**
  - If `mtvec[1:0]`=1 (vectored) and this is an interrupt entry: `{mtvec[31:2],2'b0} + 4*(16+i)`.
  - Otherwise: `{mtvec[31:2],2'b0}`.
  - `mtvec` mode values 2 and 3 are treated as direct.
- **Priority in one cycle:** `trap_i` > `irq_ack_i` > `mret_i` > CSR write.
  - The losing CSR write to `mstatus`, `mepc` or `mcause` is dropped.
  - A losing CSR write to any other register still takes effect.
- **Counters:**
  - `mcycle` increments every cycle; `minstret` increments on `instret_i`. Both wrap at 2^64-1 to 0.
  - A CSR write to either half of a counter loads that half, and suppresses that counter's increment for that cycle.

## Timing
- `rd_o`, `illegal_o`, `irq_req_o` and `trap_pc_o` are combinational from current state and inputs.
- All state updates happen at the `clk_i` rising edge.
- `irq_i` to `irq_req_o`: 1 cycle.
- After `mstatus.MIE` is set, `irq_req_o` can assert in the next cycle.
- After trap or interrupt entry, `irq_req_o` is 0 from the next cycle, because MIE is cleared.
- `rst_ni` low at any time returns all registers to reset values immediately, including counters mid-count and a pending request.

## Structure
- Package `csr_pkg` holds:
  - CSR address localparams.
  - `csr_op_e` (NONE/RW/RS/RC).
  - `MSTATUS_MIE_BIT`=3, `MSTATUS_MPIE_BIT`=7.
  - `IRQ_BASE`=16.
- Sub-module `csr_counter64` is instantiated twice. Ports: `clk_i`, `rst_ni`, `inc_i`, `wr_lo_i`, `wr_hi_i`, `wd_i`, `cnt_o[63:0]`.

## Test plan
- **Reset values:** hold `rst_ni`=0, then release; read every address → reset values above, `irq_req_o`=0, `trap_pc_o`=`MTVEC_RST`.
- **RW/RS/RC and illegal:**
  - RW `mscratch`=0xF0F0_F0F0, then RS 0x0F, then RC 0xF0 → reads 0xF0F0_F00F.
  - Access to 0x7C0 → `illegal_o`=1, no state change.
- **Vectored interrupt:**
  - Set `mtvec`=0x100|1, `mie`=0x30000, MIE=1; drive `irq_i`=0b11.
  - Next cycle `irq_req_o`=1 and `trap_pc_o`=0x140.
  - On ack: `mcause`=0x8000_0010, `mepc`=`pc_i`, MIE=0, MPIE=1.
- **Exception entry and mret:**
  - `trap_i` with `mcause_i`=2 and simultaneous CSR write to `mepc` → `mepc`=`pc_i`.
  - mret → MIE=1, MPIE=1.
- **Counter wrap and load:**
  - Write `mcycleh`=0xFFFF_FFFF, `mcycle`=0xFFFF_FFFE → two cycles later the counter reads 0.
  - `minstret` counts only `instret_i` pulses.
- **Reset mid-operation:** assert `rst_ni` while `irq_req_o`=1 and counters run → all cleared asynchronously, before the next edge.
